// File: rtl/noc_output_port_arbiter.sv
// Output-port arbiter: round-robin grant across five input blocks, locked for a whole
// packet, with a one-stage registered valid/ready slice toward the output link.
module noc_output_port_arbiter #(
    parameter int FLIT_WIDTH = 64,
    parameter int PORTS      = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            request,
    output logic [PORTS-1:0]            grant,
    input  logic [PORTS-1:0]            free,
    input  logic [PORTS-1:0]            start_of_packet,
    input  logic [PORTS-1:0]            end_of_packet,
    input  logic [PORTS-1:0]            in_valid,
    output logic [PORTS-1:0]            in_ready,
    input  logic [PORTS*FLIT_WIDTH-1:0] in_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [FLIT_WIDTH-1:0]       out_flit
);

    localparam int IDX_W = $clog2(PORTS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] pointer;
    logic             in_packet;
    logic             pending_free;

    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             pick_valid;
    logic             slice_open;
    logic             accept;
    logic             release_now;

    // Scan downward so the candidate closest after the pointer is the last one written.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        pick       = '0;
        cand       = '0;
        pick_valid = 1'b0;
        for (int k = PORTS; k >= 1; k--) begin
            cand = IDX_W'((int'(pointer) + k) % PORTS);
            if (request[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    assign slice_open  = !out_valid || out_ready;
    assign in_ready    = (state == BUSY && slice_open) ? grant : '0;
    assign accept      = (state == BUSY) && in_valid[owner] && slice_open;
    assign release_now = (free[owner] && (!in_packet || end_of_packet[owner]))
                       || (pending_free && end_of_packet[owner]);

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            owner        <= '0;
            pointer      <= IDX_W'(PORTS - 1);
            in_packet    <= 1'b0;
            pending_free <= 1'b0;
            out_valid    <= 1'b0;
            out_flit     <= '0;
        end else begin
            // The slice drains on its own, independent of whether the grant is still held.
            if (accept) begin
                out_flit  <= in_flit[owner*FLIT_WIDTH +: FLIT_WIDTH];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == IDLE) begin
                if (pick_valid) begin
                    state <= BUSY;
                    owner <= pick;
                    grant <= PORTS'(1) << pick;
                end
            end else begin
                if (start_of_packet[owner] && !end_of_packet[owner]) begin
                    in_packet <= 1'b1;
                end else if (end_of_packet[owner]) begin
                    in_packet <= 1'b0;
                end

                if (release_now) begin
                    state        <= IDLE;
                    grant        <= '0;
                    pointer      <= owner;
                    pending_free <= 1'b0;
                end else if (free[owner] && in_packet) begin
                    // Requester let go mid-packet: hold the lock until its tail flit.
                    pending_free <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Scoreboard bench for noc_output_port_arbiter: a behavioural model predicts grant,
// in_ready and out_valid each cycle and queues expected flits for a separate monitor.
module tb_noc_output_port_arbiter;

    localparam int W = 64;
    localparam int P = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [P-1:0]   request = '0;
    logic [P-1:0]   free = '0;
    logic [P-1:0]   sop = '0;
    logic [P-1:0]   eop = '0;
    logic [P-1:0]   in_valid = '0;
    logic [P*W-1:0] in_flit = '0;
    logic           out_ready = 1'b0;
    logic [P-1:0]   grant;
    logic [P-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_flit;

    noc_output_port_arbiter #(.FLIT_WIDTH(W), .PORTS(P)) dut (
        .clk(clk), .rst(rst), .request(request), .grant(grant), .free(free),
        .start_of_packet(sop), .end_of_packet(eop), .in_valid(in_valid),
        .in_ready(in_ready), .in_flit(in_flit), .out_valid(out_valid),
        .out_ready(out_ready), .out_flit(out_flit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner -1 means no grant held.
    int           m_owner = -1;
    int           m_ptr = 4;
    bit           m_inpkt = 1'b0;
    bit           m_pend = 1'b0;
    bit           m_ov = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_flit(input int i, input logic [W-1:0] v);
        in_flit[i*W +: W] = v;
    endtask

    task automatic clear_inputs();
        request = '0; free = '0; sop = '0; eop = '0; in_valid = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [P-1:0] v);
        for (int i = 0; i < P; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [P-1:0] exp_grant();
        return (m_owner < 0) ? '0 : (P'(1) << m_owner);
    endfunction

    // Model: advance on each rising edge from the inputs held since the falling edge.
    initial begin
        logic [2:0] o3;
        logic [2:0] c;
        bit         acc;
        bit         rel;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1; m_ptr = 4; m_inpkt = 0; m_pend = 0; m_ov = 0;
                exp_q.delete();
            end else begin
                o3  = 3'((m_owner < 0) ? 0 : m_owner);
                acc = (m_owner >= 0) && in_valid[o3] && (!m_ov || out_ready);
                if (acc) begin
                    exp_q.push_back(in_flit[o3*W +: W]);
                    m_ov = 1'b1;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
                if (m_owner < 0) begin
                    for (int k = 1; k <= P; k++) begin
                        c = 3'((m_ptr + k) % P);
                        if (request[c]) begin
                            m_owner = int'(c);
                            break;
                        end
                    end
                end else begin
                    rel = (free[o3] && (!m_inpkt || eop[o3])) || (m_pend && eop[o3]);
                    if (free[o3] && m_inpkt && !eop[o3]) m_pend = 1'b1;
                    if (sop[o3] && !eop[o3]) m_inpkt = 1'b1;
                    else if (eop[o3]) m_inpkt = 1'b0;
                    if (rel) begin
                        m_ptr = int'(o3); m_owner = -1; m_pend = 1'b0;
                    end
                end
            end
            #2;
            check("grant", W'(grant), W'(exp_grant()));
            check("out_valid", W'(out_valid), W'(m_ov));
        end
    end

    // Monitor: once falling-edge stimulus settles, check in_ready and pop delivered flits.
    initial begin
        logic [P-1:0] er;
        forever begin
            @(negedge clk);
            #1;
            er = (m_owner >= 0 && (!m_ov || out_ready)) ? exp_grant() : '0;
            check("in_ready", W'(in_ready), W'(er));
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_flit: got %h expected none", out_flit);
                end else begin
                    check("out_flit_sb", out_flit, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int           order[$];
        int           g;
        int           exp_order[6] = '{0, 1, 2, 3, 4, 0};

        // 3-flit packet on requester 0.
        apply_reset();
        out_ready = 1'b1;
        request = 5'b00001;
        @(negedge clk);
        check("t1_grant", W'(grant), W'(5'b00001));
        in_valid[0] = 1'b1; sop[0] = 1'b1; set_flit(0, 64'hA0);
        @(negedge clk);
        check("t1_a0", out_flit, 64'hA0);
        sop[0] = 1'b0; set_flit(0, 64'hA1);
        @(negedge clk);
        check("t1_a1", out_flit, 64'hA1);
        eop[0] = 1'b1; free[0] = 1'b1; set_flit(0, 64'hA2);
        @(negedge clk);
        check("t1_a2", out_flit, 64'hA2);
        check("t1_release", W'(grant), 64'h0);
        clear_inputs();

        // All requesting: round-robin order from the reset pointer.
        apply_reset();
        out_ready = 1'b1;
        request = '1;
        repeat (12) begin
            @(negedge clk);
            sop = '0; eop = '0; free = '0; in_valid = '0;
            if (grant != '0) begin
                g = onehot_idx(grant);
                order.push_back(g);
                sop[g] = 1'b1; eop[g] = 1'b1; free[g] = 1'b1; in_valid[g] = 1'b1;
                set_flit(g, {32'hC0DE_0000, 32'(g)});
            end
        end
        clear_inputs();
        check("rr_count", W'(order.size()), 64'd6);
        for (int i = 0; i < order.size() && i < 6; i++)
            check("rr_order", W'(order[i]), W'(exp_order[i]));

        // Early free, 4-cycle stall, and noise on a non-granted requester.
        apply_reset();
        out_ready = 1'b1;
        request = 5'b00100;
        @(negedge clk);
        check("t3_grant", W'(grant), W'(5'b00100));
        request = 5'b00010;
        sop[2] = 1'b1; in_valid[2] = 1'b1; set_flit(2, 64'hB0);
        free[1] = 1'b1; sop[1] = 1'b1; eop[1] = 1'b1; in_valid[1] = 1'b1; set_flit(1, 64'hDEAD);
        @(negedge clk);
        check("t3_b0", out_flit, 64'hB0);
        sop[2] = 1'b0; free[2] = 1'b1; out_ready = 1'b0; set_flit(2, 64'hB1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            free[2] = 1'b0;
            check("t3_stall_ready", W'(in_ready), 64'h0);
            check("t3_stall_flit", out_flit, 64'hB0);
            check("t3_hold_grant", W'(grant), W'(5'b00100));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_b1", out_flit, 64'hB1);
        check("t3_pending", W'(grant), W'(5'b00100));
        eop[2] = 1'b1; set_flit(2, 64'hB2);
        @(negedge clk);
        check("t3_b2", out_flit, 64'hB2);
        check("t3_release", W'(grant), 64'h0);
        clear_inputs();

        // Reset while busy with a flit held in the slice.
        apply_reset();
        out_ready = 1'b0;
        request = 5'b00001;
        @(negedge clk);
        in_valid[0] = 1'b1; set_flit(0, 64'hD0);
        @(negedge clk);
        check("t6_ov", W'(out_valid), 64'h1);
        in_valid = '0; rst = 1'b1;
        @(negedge clk);
        check("t6_rst_grant", W'(grant), 64'h0);
        check("t6_rst_ov", W'(out_valid), 64'h0);
        rst = 1'b0; request = 5'b00010;
        @(negedge clk);
        check("t6_grant", W'(grant), W'(5'b00010));
        clear_inputs();

        // Randomized traffic checked entirely by the model.
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < P; i++) begin
                request[i]  = ($urandom_range(0, 99) < 40);
                sop[i]      = ($urandom_range(0, 99) < 20);
                eop[i]      = ($urandom_range(0, 99) < 20);
                free[i]     = ($urandom_range(0, 99) < 15);
                in_valid[i] = ($urandom_range(0, 99) < 70);
                set_flit(i, {$urandom, $urandom});
            end
            out_ready = ($urandom_range(0, 99) < 70);
            if (m_owner >= 0 && free[m_owner] && sop[m_owner] && !eop[m_owner])
                free[m_owner] = 1'b0;
        end

        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("drain_empty", W'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_output_port_arbiter.md
Name: noc_output_port_arbiter

Overview:
- Responder end of the port-control handshake. Sits on the output side of each router output port.
- Arbitrates between the five input blocks (xp, xm, yp, ym, l) requesting that port and grants one of them, round-robin.
- Locks the grant for the whole packet and releases it when the granted requester frees the port.
- Forwards the granted input's flits through a one-stage registered valid/ready slice to the output link.

Parameters:
- FLIT_WIDTH, 64, width of one flit in bits.
- PORTS, 5, number of requesters. Fixed at 5; index 0..4 = xp, xm, yp, ym, l.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- request  input  PORTS  per-requester port request
- grant  output  PORTS  one-hot grant, registered
- free  input  PORTS  requester releases port
- start_of_packet  input  PORTS  head flit accepted by requester side
- end_of_packet  input  PORTS  tail flit accepted by requester side
- in_valid  input  PORTS  per-input flit valid
- in_ready  output  PORTS  per-input flit ready
- in_flit  input  PORTS*FLIT_WIDTH  per-input flit; slice i = bits [i*FLIT_WIDTH +: FLIT_WIDTH]
- out_valid  output  1  output flit valid, registered
- out_ready  input  1  downstream ready
- out_flit  output  FLIT_WIDTH  output flit, registered

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - grant=0, out_valid=0, out_flit=0
  - state=IDLE, in_packet=0, pending_free=0
  - priority pointer = 4, so requester 0 has top priority after reset.
- Reset mid-packet discards the slice contents and any lock immediately.
- State IDLE:
  - If any request bit is set, pick the first set bit scanning from pointer+1 upward, wrapping modulo 5.
  - Next cycle: grant = one-hot of the pick, state = BUSY.
  - Latency from request to grant is 1 cycle.
- State BUSY, granted index g:
  - grant is held even if request[g] drops.
  - request, free, start_of_packet and end_of_packet from non-granted indices are ignored.
- in_packet flag:
  - Set on start_of_packet[g].
  - Cleared on end_of_packet[g].
  - If start_of_packet[g] and end_of_packet[g] occur together (single-flit packet), in_packet stays 0.
- Release rule:
  - free[g] when in_packet=0, or together with end_of_packet[g] → release.
  - free[g] while in_packet=1 and no end_of_packet[g] → set pending_free; release on the later end_of_packet[g].
  - On release, next cycle: grant=0, state=IDLE, pointer=g, pending_free=0.
  - No new grant is issued in the release cycle, so there is always one IDLE cycle between grants.
- Flit slice:
  - in_ready[i] = (state==BUSY) & grant[i] & (!out_valid | out_ready). All other in_ready bits are 0.
  - On in_valid[g] & in_ready[g]: out_flit <= in_flit slice g, out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - Latency is 1 cycle; full throughput of 1 flit/cycle when out_ready is held high.
  - out_valid and out_flit are held stable while out_valid & !out_ready.
  - The slice drains independently of grant, so a flit still in the slice after release is delivered normally.
- Round-robin guarantees no starvation: a requester waits at most 4 other grants.

Test Plan:
- Reset, then request=5'b00001 → grant=5'b00001 one cycle later. Send a 3-flit packet A0,A1,A2 with sop on A0, eop on A2, free with A2 → out_flit A0,A1,A2 on consecutive cycles; grant=0 the cycle after free.
- request=5'b11111 held, pointer at reset value → grants issued in order 0,1,2,3,4,0, each a single-flit packet, each grant separated by one idle cycle.
- free[g] asserted after sop but before eop → grant stays set; deasserted the cycle after eop[g] arrives.
- out_ready held 0 for 4 cycles mid-packet → out_flit stable, in_ready[g]=0. Resume → no flit lost or duplicated.
- free, sop and flit valid driven on a non-granted index → no effect on grant, in_ready or out_flit.
- rst asserted while BUSY with out_valid=1 → next cycle grant=0, out_valid=0. A fresh request=5'b00010 → grant=5'b00010.
